branch_predictor: RTL and testbench

- Fetch-side counterpart to execute-stage branch resolution.
- Predicts direction and target for the PC in Fetch from a direct-mapped BTB with 2-bit saturating counters.
- Learns from branch outcomes resolved in Execute: the resolved branch-taken flag, PC and computed target arrive on the update port.
- Drives the PC-select mux in Fetch. Reports a mispredict so hazard logic can flush.

---
 rtl/branch_pred_pkg.sv | 35 +++
 rtl/sat_counter_2b.sv | 20 ++
 rtl/branch_predictor.sv | 140 ++++++++++++++
 tb/tb_branch_predictor.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/branch_pred_pkg.sv
// Shared types and constants for the BTB branch predictor.
// bp_entry_t field widths match the default branch_predictor parameters.
package branch_pred_pkg;

  localparam int BP_DATA_WIDTH = 32;
  localparam int BP_INDEX_BITS = 4;
  localparam int BP_TAG_BITS   = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  typedef struct packed {
    logic                     valid;
    logic [BP_TAG_BITS-1:0]   tag;
    logic [BP_DATA_WIDTH-1:0] target;
    bp_ctr_t                  ctr;
  } bp_entry_t;

  localparam bp_ctr_t BP_CTR_RESET = WNT;
  localparam bp_ctr_t BP_CTR_ALLOC = WT;

  function automatic bp_entry_t bp_entry_reset();
    bp_entry_t e;
    e.valid  = 1'b0;
    e.tag    = '0;
    e.target = '0;
    e.ctr    = BP_CTR_RESET;
    return e;
  endfunction

endpackage

// File: rtl/sat_counter_2b.sv
// Two-bit saturating direction counter: next state from current state and outcome.
// Pure combinational; saturates at SNT and ST.
module sat_counter_2b
  import branch_pred_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (bp_ctr_t'(ctr_i) != ST) ctr_o = ctr_i + 2'b01;
    end else begin
      if (bp_ctr_t'(ctr_i) != SNT) ctr_o = ctr_i - 2'b01;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor with 2-bit counters; combinational predict, registered update.
// Define BRANCH_PRED_GSHARE_EN to move counters into a GHR-indexed pattern table.
module branch_predictor
  import branch_pred_pkg::*;
#(
  parameter int DATA_WIDTH = BP_DATA_WIDTH,
  parameter int INDEX_BITS = BP_INDEX_BITS,
  parameter int TAG_BITS   = BP_TAG_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] PCF_i,
  output logic                  PredictTaken_o,
  output logic [DATA_WIDTH-1:0] PredictTarget_o,
  input  logic                  UpdateEn_i,
  input  logic [DATA_WIDTH-1:0] UpdatePC_i,
  input  logic                  UpdateTaken_i,
  input  logic [DATA_WIDTH-1:0] UpdateTarget_i,
  input  logic                  UpdatePredTaken_i,
  input  logic [DATA_WIDTH-1:0] UpdatePredTarget_i,
  output logic                  Mispredict_o
);

  localparam int NUM_ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LSB     = INDEX_BITS + 2;
  localparam int TAG_MSB     = INDEX_BITS + TAG_BITS + 1;

  bp_entry_t table_q [NUM_ENTRIES];
  bp_entry_t upd_entry_d;
  logic      upd_we;

  logic [INDEX_BITS-1:0] pcf_idx, upd_idx;
  logic [TAG_BITS-1:0]   pcf_tag, upd_tag;
  bp_entry_t             pcf_entry, upd_entry;
  logic                  pcf_hit, upd_hit;
  logic [1:0]            pcf_ctr, upd_ctr, upd_ctr_next;

  assign pcf_idx   = PCF_i[INDEX_BITS+1:2];
  assign pcf_tag   = PCF_i[TAG_MSB:TAG_LSB];
  assign upd_idx   = UpdatePC_i[INDEX_BITS+1:2];
  assign upd_tag   = UpdatePC_i[TAG_MSB:TAG_LSB];
  assign pcf_entry = table_q[pcf_idx];
  assign upd_entry = table_q[upd_idx];
  assign pcf_hit   = pcf_entry.valid && (pcf_entry.tag == pcf_tag);
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  sat_counter_2b u_sat_counter (
    .ctr_i   (upd_ctr),
    .taken_i (UpdateTaken_i),
    .ctr_o   (upd_ctr_next)
  );

`ifdef BRANCH_PRED_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q, ghr_d;
  bp_ctr_t               pht_q [NUM_ENTRIES];
  logic [INDEX_BITS-1:0] pht_rd_idx, pht_wr_idx;
  logic                  pht_we;
  bp_ctr_t               pht_wdata;
  logic                  unused_entry_ctr;

  // Counter update uses the pre-shift history, matching the index used when predicting.
  assign pht_rd_idx       = pcf_idx ^ ghr_q;
  assign pht_wr_idx       = upd_idx ^ ghr_q;
  assign pcf_ctr          = pht_q[pht_rd_idx];
  assign upd_ctr          = pht_q[pht_wr_idx];
  assign unused_entry_ctr = ^{pcf_entry.ctr, upd_entry.ctr};

  always_comb begin
    ghr_d     = ghr_q;
    pht_we    = 1'b0;
    pht_wdata = bp_ctr_t'(upd_ctr_next);
    if (UpdateEn_i) begin
      ghr_d = {ghr_q[INDEX_BITS-2:0], UpdateTaken_i};
      if (upd_hit) begin
        pht_we = 1'b1;
      end else if (UpdateTaken_i) begin
        pht_we    = 1'b1;
        pht_wdata = BP_CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ghr_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) pht_q[i] <= BP_CTR_RESET;
    end else begin
      ghr_q <= ghr_d;
      if (pht_we) pht_q[pht_wr_idx] <= pht_wdata;
    end
  end
`else
  assign pcf_ctr = pcf_entry.ctr;
  assign upd_ctr = upd_entry.ctr;
`endif

  always_comb begin
    upd_we      = 1'b0;
    upd_entry_d = upd_entry;
    if (UpdateEn_i) begin
      if (upd_hit) begin
`ifndef BRANCH_PRED_GSHARE_EN
        upd_we          = 1'b1;
        upd_entry_d.ctr = bp_ctr_t'(upd_ctr_next);
`endif
        if (UpdateTaken_i) begin
          upd_we             = 1'b1;
          upd_entry_d.target = UpdateTarget_i;
        end
      end else if (UpdateTaken_i) begin
        upd_we             = 1'b1;
        upd_entry_d.valid  = 1'b1;
        upd_entry_d.tag    = upd_tag;
        upd_entry_d.target = UpdateTarget_i;
        upd_entry_d.ctr    = BP_CTR_ALLOC;
      end
    end
  end

  // No write-to-read bypass: a same-cycle update is seen by predict one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) table_q[i] <= bp_entry_reset();
    end else if (upd_we) begin
      table_q[upd_idx] <= upd_entry_d;
    end
  end

  assign PredictTaken_o  = pcf_hit && pcf_ctr[1];
  assign PredictTarget_o = PredictTaken_o ? pcf_entry.target : PCF_i + DATA_WIDTH'(4);

  assign Mispredict_o = UpdateEn_i &&
                        ((UpdateTaken_i != UpdatePredTaken_i) ||
                         (UpdateTaken_i && (UpdateTarget_i != UpdatePredTarget_i)));

  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF_i[1:0], PCF_i[DATA_WIDTH-1:TAG_MSB+1],
                            UpdatePC_i[1:0], UpdatePC_i[DATA_WIDTH-1:TAG_MSB+1]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default build, per-entry counters).
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] PCF_i;
  logic        PredictTaken_o;
  logic [31:0] PredictTarget_o;
  logic        UpdateEn_i;
  logic [31:0] UpdatePC_i;
  logic        UpdateTaken_i;
  logic [31:0] UpdateTarget_i;
  logic        UpdatePredTaken_i;
  logic [31:0] UpdatePredTarget_i;
  logic        Mispredict_o;

  int tests_run = 0;
  int tests_failed = 0;

  branch_predictor dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .PCF_i              (PCF_i),
    .PredictTaken_o     (PredictTaken_o),
    .PredictTarget_o    (PredictTarget_o),
    .UpdateEn_i         (UpdateEn_i),
    .UpdatePC_i         (UpdatePC_i),
    .UpdateTaken_i      (UpdateTaken_i),
    .UpdateTarget_i     (UpdateTarget_i),
    .UpdatePredTaken_i  (UpdatePredTaken_i),
    .UpdatePredTarget_i (UpdatePredTarget_i),
    .Mispredict_o       (Mispredict_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pred(input string tag, input logic [31:0] pc,
                      input logic exp_taken, input logic [31:0] exp_tgt);
    PCF_i = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, PredictTaken_o}, {31'd0, exp_taken});
    chk({tag, "_target"}, PredictTarget_o, exp_tgt);
  endtask

  // Presents one resolved branch for a single cycle and checks the mispredict flag.
  task automatic upd(input string tag, input logic [31:0] pc, input logic taken,
                     input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt,
                     input logic exp_mp);
    UpdateEn_i         = 1'b1;
    UpdatePC_i         = pc;
    UpdateTaken_i      = taken;
    UpdateTarget_i     = tgt;
    UpdatePredTaken_i  = ptaken;
    UpdatePredTarget_i = ptgt;
    #1;
    chk({tag, "_mispredict"}, {31'd0, Mispredict_o}, {31'd0, exp_mp});
    tick();
    UpdateEn_i = 1'b0;
  endtask

  initial begin
    rst_i              = 1'b1;
    PCF_i              = 32'h40;
    UpdateEn_i         = 1'b0;
    UpdatePC_i         = '0;
    UpdateTaken_i      = 1'b0;
    UpdateTarget_i     = '0;
    UpdatePredTaken_i  = 1'b0;
    UpdatePredTarget_i = '0;

    tick();
    tick();
    pred("in_reset", 32'h40, 1'b0, 32'h44);
    rst_i = 1'b0;
    tick();
    pred("after_reset", 32'h40, 1'b0, 32'h44);
    chk("after_reset_mispredict", {31'd0, Mispredict_o}, 32'd0);

    // First allocation with predict of the same PC in the same cycle: old entry seen.
    PCF_i              = 32'h40;
    UpdateEn_i         = 1'b1;
    UpdatePC_i         = 32'h40;
    UpdateTaken_i      = 1'b1;
    UpdateTarget_i     = 32'h20;
    UpdatePredTaken_i  = 1'b0;
    UpdatePredTarget_i = 32'h44;
    #1;
    chk("alloc_mispredict", {31'd0, Mispredict_o}, 32'd1);
    chk("same_cycle_taken", {31'd0, PredictTaken_o}, 32'd0);
    chk("same_cycle_target", PredictTarget_o, 32'h44);
    tick();
    UpdateEn_i = 1'b0;
    pred("post_alloc", 32'h40, 1'b1, 32'h20);
    pred("alias_440", 32'h440, 1'b0, 32'h444);

    // WT -> WNT -> SNT
    upd("nt1", 32'h40, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1);
    pred("wnt", 32'h40, 1'b0, 32'h44);
    upd("nt2", 32'h40, 1'b0, 32'h0, 1'b0, 32'h44, 1'b0);
    pred("snt", 32'h40, 1'b0, 32'h44);

    // SNT -> WNT -> WT -> ST, then saturate at ST
    upd("t1", 32'h40, 1'b1, 32'h20, 1'b0, 32'h44, 1'b1);
    pred("t1_wnt", 32'h40, 1'b0, 32'h44);
    upd("t2", 32'h40, 1'b1, 32'h20, 1'b0, 32'h44, 1'b1);
    pred("t2_wt", 32'h40, 1'b1, 32'h20);
    upd("t3_newtgt", 32'h40, 1'b1, 32'h30, 1'b1, 32'h20, 1'b1);
    pred("t3_st", 32'h40, 1'b1, 32'h30);
    upd("t4", 32'h40, 1'b1, 32'h30, 1'b1, 32'h30, 1'b0);
    pred("t4_st", 32'h40, 1'b1, 32'h30);
    upd("nt_from_st", 32'h40, 1'b0, 32'h0, 1'b1, 32'h30, 1'b1);
    pred("wt_after_st", 32'h40, 1'b1, 32'h30);

    // Disabled update with live-looking inputs leaves everything alone.
    UpdatePC_i         = 32'h40;
    UpdateTaken_i      = 1'b1;
    UpdateTarget_i     = 32'h99;
    UpdatePredTaken_i  = 1'b0;
    UpdatePredTarget_i = 32'h0;
    #1;
    chk("disabled_mispredict", {31'd0, Mispredict_o}, 32'd0);
    tick();
    pred("disabled_unchanged", 32'h40, 1'b1, 32'h30);

    // Miss not-taken on the alias leaves the resident entry in place.
    upd("miss_nt", 32'h440, 1'b0, 32'h0, 1'b0, 32'h444, 1'b0);
    pred("miss_nt_keep", 32'h40, 1'b1, 32'h30);
    pred("low_bits_ignored", 32'h43, 1'b1, 32'h30);
    pred("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Bring the entry back to ST, then reset with a concurrent update.
    upd("t5", 32'h40, 1'b1, 32'h30, 1'b1, 32'h30, 1'b0);
    pred("t5_st", 32'h40, 1'b1, 32'h30);
    rst_i              = 1'b1;
    UpdateEn_i         = 1'b1;
    UpdatePC_i         = 32'h40;
    UpdateTaken_i      = 1'b1;
    UpdateTarget_i     = 32'h50;
    tick();
    rst_i      = 1'b0;
    UpdateEn_i = 1'b0;
    pred("reset_wins", 32'h40, 1'b0, 32'h44);
    tick();
    pred("reset_wins_later", 32'h40, 1'b0, 32'h44);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
